// File: rtl/ram_bist_ctrl.sv
// March-less fill/readback BIST master for a single-port RAM.
// Optional random readback phase: define RAND_PHASE_EN.
module ram_bist_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8
`ifdef RAND_PHASE_EN
    ,
    parameter int N_RAND = 20,
    parameter int LFSR_SEED = 35,
    parameter logic [AW-1:0] LFSR_TAPS = 10'h240
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic          ram_select,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [15:0]   err_count,
    output logic [AW-1:0] fail_addr
);

    localparam int DEPTH = 2**AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RND,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_addr;
    logic [DW-1:0] r_pat_unused_guard;
    logic [DW-1:0] w_pat;
    logic [DW-1:0] w_exp;
    logic          w_last;
    logic          w_end;
    logic          w_cmp;
    logic          w_mis;
    logic          w_go;
    logic          r_fail;
    logic [15:0]   r_err;
    logic [AW-1:0] r_faddr;

`ifdef RAND_PHASE_EN
    localparam logic [AW-1:0] SEED_T = AW'(LFSR_SEED);
    localparam logic [AW-1:0] SEED_V = (SEED_T == '0) ? AW'(1) : SEED_T;

    logic [AW-1:0] r_lfsr;
    logic [AW-1:0] w_lfsr_nx;
    logic          w_rnd_last;

    assign w_lfsr_nx  = {r_lfsr[AW-2:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_rnd_last = (r_addr == (AW+1)'(N_RAND-1));
`endif

    assign w_go   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last = (r_addr == (AW+1)'(DEPTH-1));
    assign w_pat  = DW'(r_addr + (AW+1)'(1));
    assign w_mis  = w_cmp && (ram_dout != w_exp);

    assign busy      = (r_state == S_WR) || (r_state == S_RD) ||
                       (r_state == S_RND);
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign err_count = r_err;
    assign fail_addr = r_faddr;

    // State register; reset abandons any running test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and RAM-side outputs, decoded from the current phase.
    always_comb begin
        w_next     = r_state;
        ram_din    = '0;
        ram_addr   = '0;
        ram_write  = 1'b0;
        ram_select = 1'b0;
        w_cmp      = 1'b0;
        w_exp      = w_pat;
        w_end      = 1'b0;
        r_pat_unused_guard = '0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = S_WR;
            end
            S_WR: begin
                ram_select = 1'b1;
                ram_write  = 1'b1;
                ram_addr   = r_addr[AW-1:0];
                ram_din    = w_pat;
                w_end      = w_last;
                if (w_last) w_next = S_RD;
            end
            S_RD: begin
                ram_select = 1'b1;
                ram_addr   = r_addr[AW-1:0];
                w_cmp      = 1'b1;
                w_end      = w_last;
`ifdef RAND_PHASE_EN
                if (w_last) w_next = S_RND;
`else
                if (w_last) w_next = S_DONE;
`endif
            end
`ifdef RAND_PHASE_EN
            S_RND: begin
                ram_select = 1'b1;
                ram_addr   = r_lfsr;
                w_cmp      = 1'b1;
                w_exp      = DW'(r_lfsr + AW'(1));
                w_end      = w_rnd_last;
                if (w_rnd_last) w_next = S_DONE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Address sequencing and registered compare results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_faddr <= '0;
        end else if (w_go) begin
            r_addr  <= '0;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_faddr <= '0;
        end else begin
            if (busy) r_addr <= w_end ? '0 : r_addr + (AW+1)'(1);
            if (w_mis) begin
                r_fail <= 1'b1;
                if (!r_fail) r_faddr <= ram_addr;
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            end
        end
    end

`ifdef RAND_PHASE_EN
    // LFSR is seeded at test start and steps into and through RND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= SEED_V;
        else if (w_go) r_lfsr <= SEED_V;
        else if ((r_state == S_RD && w_last) || r_state == S_RND)
            r_lfsr <= w_lfsr_nx;
    end
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a behavioural 1Kx8 RAM
// and per-address stuck/invert fault injection on the read path.
module tb_ram_bist_ctrl;

    localparam int DEPTH = 1024;
`ifdef RAND_PHASE_EN
    localparam int LAT = 2*DEPTH + 20 + 1;
`else
    localparam int LAT = 2*DEPTH + 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [9:0]  ram_addr;
    logic        ram_write;
    logic        ram_select;
    logic        busy;
    logic        done;
    logic        fail;
    logic [15:0] err_count;
    logic [9:0]  fail_addr;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  w_d;
    int          fmode;
    bit          flt_on;
    int          n_chk;
    int          n_err;

    ram_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_dout(ram_dout), .ram_din(ram_din), .ram_addr(ram_addr),
        .ram_write(ram_write), .ram_select(ram_select),
        .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_select && ram_write) mem[ram_addr] <= ram_din;

    always_comb begin
        w_d = mem[ram_addr];
        if (flt_on) begin
            case (fmode)
                1: if (ram_addr == 10'd5 || ram_addr == 10'd700) w_d[0] = 1'b1;
                2: if (ram_addr == 10'd5 || ram_addr == 10'd700) w_d[1] = 1'b1;
                3: if (ram_addr == 10'd600 || ram_addr == 10'd900) w_d[0] = ~w_d[0];
                default: ;
            endcase
        end
        ram_dout = w_d;
    end

    typedef struct {
        int fm;
        bit poke;
        int e_fail;
        int e_err;
        int e_faddr;
    } vec_t;

    vec_t tv [5];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int allz();
        return int'((busy | done | fail | ram_write | ram_select) == 1'b0 &&
                    err_count == 16'd0 && fail_addr == 10'd0 &&
                    ram_din == 8'd0 && ram_addr == 10'd0);
    endfunction

    task automatic run_test(input bit hold, input bit poke);
        int lat;
        int bad;
        int c;
        lat = -1;
        bad = 0;
        flt_on = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk); #1;
            if (!hold) start = poke && (i == 1500 || i == 1800);
            c = i - 1;
            if (c >= 2*DEPTH) flt_on = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy || !ram_select) bad++;
            else if (c < DEPTH) begin
                if (!ram_write || ram_addr != 10'(c) || ram_din != 8'(c + 1))
                    bad++;
            end else if (c < 2*DEPTH) begin
                if (ram_write || ram_addr != 10'(c - DEPTH) || ram_din != 8'd0)
                    bad++;
            end else if (ram_write) bad++;
        end
        check("latency", lat, LAT);
        check("wr_rd_seq", bad, 0);
        check("done_bus_idle", int'({busy, ram_select, ram_write}), 0);
    endtask

    initial begin
        int bad;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        fmode = 0;
        flt_on = 1'b0;

        tv[0] = '{fm: 0, poke: 1'b0, e_fail: 0, e_err: 0, e_faddr: 0};
        tv[1] = '{fm: 1, poke: 1'b0, e_fail: 1, e_err: 1, e_faddr: 5};
        tv[2] = '{fm: 2, poke: 1'b0, e_fail: 1, e_err: 1, e_faddr: 700};
        tv[3] = '{fm: 3, poke: 1'b0, e_fail: 1, e_err: 2, e_faddr: 600};
        tv[4] = '{fm: 0, poke: 1'b1, e_fail: 0, e_err: 0, e_faddr: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_zero", allz(), 1);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (allz() == 0) bad++;
        end
        check("idle_zero", bad, 0);

        for (int k = 0; k < 5; k++) begin
            fmode = tv[k].fm;
            run_test(1'b0, tv[k].poke);
            check("fail", int'(fail), tv[k].e_fail);
            check("err_count", int'(err_count), tv[k].e_err);
            check("fail_addr", int'(fail_addr), tv[k].e_faddr);
        end

        fmode = 1;
        run_test(1'b1, 1'b0);
        check("rerun_fail_before", int'(fail), 1);
        fmode = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("rerun_busy", int'({busy, done}), 2);
        check("rerun_cleared", int'({fail, err_count, fail_addr}), 0);
        check("rerun_first_wr", int'({ram_write, ram_addr, ram_din}), 1*2**18 + 1);
        bad = -1;
        for (int i = 2; i <= 3000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                bad = i;
                break;
            end
        end
        check("rerun_latency", bad, LAT);
        check("rerun_fail_after", int'(fail), 0);

        fmode = 0;
        start = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ram_write && ram_addr == 10'd300) begin
                bad = 1;
                break;
            end
        end
        check("mid_reached_300", bad, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_zero", allz(), 1);
        @(posedge clk); #1;
        check("mid_reset_hold", allz(), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_idle", allz(), 1);
        run_test(1'b0, 1'b0);
        check("after_reset_clean", int'({fail, err_count}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
